// File: rtl/tm1637_pkg.sv
// TM1637 display link: shared state encoding, command bytes and 7-segment glyphs.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tm1637_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RS_A,   // SCL0, SDA1: prepare repeated start
        RS_B,   // SCL1, SDA1
        ST_A,   // SCL1, SDA0: START edge
        ST_B,   // SCL0, SDA0
        BIT_LO, // SCL0, SDA=bit
        BIT_HI, // SCL1, SDA=bit
        ACK_LO, // SCL0, SDA released
        ACK_HI, // SCL1, SDA released, device ACK sampled at end
        SP_A,   // SCL0, SDA0
        SP_B,   // SCL1, SDA0
        SP_C    // SCL1, SDA released: STOP edge
    } state_t;

    // Command bytes understood by the TM1637.
    localparam logic [7:0] C_DATA_AUTO = 8'h40;
    localparam logic [7:0] C_ADDR0     = 8'hC0;
    localparam logic [7:0] C_DISP_ON   = 8'h88;

    // Display-on command with brightness 0..7 in the low bits.
    function automatic logic [7:0] disp_on(input logic [2:0] brightness);
        return C_DISP_ON | {5'b0, brightness};
    endfunction

    // Segment pattern (bit0 = seg a .. bit6 = seg g) for a hex digit.
    function automatic logic [7:0] seg_glyph(input logic [3:0] nibble);
        logic [7:0] g;
        case (nibble)
            4'h0: g = 8'h3F;  4'h1: g = 8'h06;  4'h2: g = 8'h5B;  4'h3: g = 8'h4F;
            4'h4: g = 8'h66;  4'h5: g = 8'h6D;  4'h6: g = 8'h7D;  4'h7: g = 8'h07;
            4'h8: g = 8'h7F;  4'h9: g = 8'h6F;  4'hA: g = 8'h77;  4'hB: g = 8'h7C;
            4'hC: g = 8'h39;  4'hD: g = 8'h5E;  4'hE: g = 8'h79;  default: g = 8'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/tm1637_link.sv
// TM1637 byte link: sends one byte LSB first with optional START/STOP and checks the ACK.
// Latency: N*CLK_DIV cycles accept-to-DONE, N = 18 (+2 START) (+2 restart) (+3 STOP/NACK).
// Backpressure: CMD_READY low from the cycle after acceptance until DONE; no accept in the DONE cycle.
// Ports: CLK/RESET (async, active low); CMD_VALID/READY/DATA/START/STOP request handshake;
//        DONE/ACK_ERR completion, BUSY = ~CMD_READY; SCL_O, SDA_O/SDA_OE/SDA_I display lines.
module tm1637_link
    import tm1637_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [7:0] CMD_DATA,
    input  logic       CMD_START,
    input  logic       CMD_STOP,
    output logic       DONE,
    output logic       ACK_ERR,
    output logic       BUSY,
    output logic       SCL_O,
    output logic       SDA_O,
    output logic       SDA_OE,
    input  logic       SDA_I
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] data_q, data_d;
    logic       stop_q, stop_d;
    logic       bus_open_q, bus_open_d;
    logic       nack_q, nack_d;
    logic       done_q, done_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       oe_q, oe_d;

    logic       phase_end;
    logic       accept;

    assign CMD_READY = (state_q == IDLE);
    assign BUSY      = ~CMD_READY;
    assign DONE      = done_q;
    assign ACK_ERR   = done_q & nack_q;
    assign SCL_O     = scl_q;
    assign SDA_O     = sda_q;
    assign SDA_OE    = oe_q;

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        data_d     = data_q;
        stop_d     = stop_q;
        bus_open_d = bus_open_q;
        nack_d     = nack_q;
        phase_end  = (div_q == DIV_LAST);
        // The DONE cycle shows READY=1 but must not take a new request.
        accept     = CMD_VALID & CMD_READY & ~done_q;

        // Divider idles at zero, so it restarts on acceptance.
        div_d = (state_q == IDLE || phase_end) ? 8'd0 : div_q + 8'd1;

        case (state_q)
            IDLE: if (accept) begin
                data_d = CMD_DATA;
                stop_d = CMD_STOP;
                bit_d  = 3'd0;
                nack_d = 1'b0;
                if (CMD_START && bus_open_q)       state_d = RS_A;
                else if (CMD_START || !bus_open_q) state_d = ST_A;  // closed bus always gets a START
                else                               state_d = BIT_LO;
            end
            RS_A:   if (phase_end) state_d = RS_B;
            RS_B:   if (phase_end) state_d = ST_A;
            ST_A:   if (phase_end) state_d = ST_B;
            ST_B:   if (phase_end) state_d = BIT_LO;
            BIT_LO: if (phase_end) state_d = BIT_HI;
            BIT_HI: if (phase_end) begin
                bit_d   = bit_q + 3'd1;  // wraps 7 -> 0 as the byte completes
                state_d = (bit_q == 3'd7) ? ACK_LO : BIT_LO;
            end
            ACK_LO: if (phase_end) state_d = ACK_HI;
            ACK_HI: if (phase_end) begin
                nack_d  = SDA_I;
                // A NACK always closes the bus so the device starts fresh.
                state_d = (stop_q || SDA_I) ? SP_A : IDLE;
            end
            SP_A:   if (phase_end) state_d = SP_B;
            SP_B:   if (phase_end) state_d = SP_C;
            SP_C:   if (phase_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == ST_A)      bus_open_d = 1'b1;
        else if (state_d == SP_C) bus_open_d = 1'b0;

        done_d = (state_q != IDLE) && (state_d == IDLE);

        // Line levels are registered from the next state so they change with it.
        scl_d = 1'b0;
        sda_d = 1'b0;
        oe_d  = 1'b1;
        case (state_d)
            IDLE:   begin scl_d = ~bus_open_d; sda_d = ~bus_open_d; oe_d = bus_open_d; end
            RS_A:   begin scl_d = 1'b0; sda_d = 1'b1;           end
            RS_B:   begin scl_d = 1'b1; sda_d = 1'b1;           end
            ST_A:   begin scl_d = 1'b1; sda_d = 1'b0;           end
            ST_B:   begin scl_d = 1'b0; sda_d = 1'b0;           end
            BIT_LO: begin scl_d = 1'b0; sda_d = data_d[bit_d];  end
            BIT_HI: begin scl_d = 1'b1; sda_d = data_d[bit_d];  end
            ACK_LO: begin scl_d = 1'b0; sda_d = 1'b1; oe_d = 1'b0; end
            ACK_HI: begin scl_d = 1'b1; sda_d = 1'b1; oe_d = 1'b0; end
            SP_A:   begin scl_d = 1'b0; sda_d = 1'b0;           end
            SP_B:   begin scl_d = 1'b1; sda_d = 1'b0;           end
            SP_C:   begin scl_d = 1'b1; sda_d = 1'b1; oe_d = 1'b0; end
            default: begin scl_d = 1'b1; sda_d = 1'b1; oe_d = 1'b0; end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            div_q      <= 8'd0;
            bit_q      <= 3'd0;
            data_q     <= 8'd0;
            stop_q     <= 1'b0;
            bus_open_q <= 1'b0;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            stop_q     <= stop_d;
            bus_open_q <= bus_open_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            oe_q       <= oe_d;
        end
    end

endmodule

// File: tb/tb_tm1637_link.sv
module tb_tm1637_link;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [7:0] CMD_DATA = 8'h00;
    logic       CMD_START = 1'b0;
    logic       CMD_STOP = 1'b0;
    logic       DONE;
    logic       ACK_ERR;
    logic       BUSY;
    logic       SCL_O;
    logic       SDA_O;
    logic       SDA_OE;
    logic       SDA_I;

    int checks = 0;
    int failures = 0;

    // Display device model: pulls DIO low during the ACK slot unless nack_mode.
    logic       dev_pull = 1'b0;
    logic       nack_mode = 1'b0;
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       m_open = 1'b0;
    int         bitcnt = 0;
    int         rs_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];

    wire sda_line = SDA_OE ? SDA_O : ~dev_pull;
    assign SDA_I = sda_line;

    tm1637_link #(.CLK_DIV(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA),
        .CMD_START(CMD_START), .CMD_STOP(CMD_STOP),
        .DONE(DONE), .ACK_ERR(ACK_ERR), .BUSY(BUSY),
        .SCL_O(SCL_O), .SDA_O(SDA_O), .SDA_OE(SDA_OE), .SDA_I(SDA_I)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dev_pull = 1'b0; scl_prev = 1'b1; sda_prev = 1'b1;
            m_open = 1'b0; bitcnt = 0; rx_byte = 8'h00;
        end else begin
            if (scl_prev && SCL_O && sda_prev && !sda_line) begin        // START
                if (m_open) rs_cnt++;
                m_open = 1'b1; bitcnt = 0; dev_pull = 1'b0;
            end else if (scl_prev && SCL_O && !sda_prev && sda_line) begin // STOP
                m_open = 1'b0; bitcnt = 0; dev_pull = 1'b0;
            end else if (!scl_prev && SCL_O) begin                        // SCL rise
                if (bitcnt < 8) rx_byte[bitcnt] = sda_line;
                bitcnt++;
            end else if (scl_prev && !SCL_O) begin                        // SCL fall
                if (bitcnt == 8) dev_pull = ~nack_mode;
                else if (bitcnt == 9) begin
                    dev_pull = 1'b0; bitcnt = 0; rx_q.push_back(rx_byte);
                end
            end
            scl_prev = SCL_O;
            sda_prev = sda_line;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the link ready; returns at the DONE negedge.
    task automatic send(input logic [7:0] d, input logic s, input logic p,
                        output int lat, output logic aerr);
        CMD_DATA = d; CMD_START = s; CMD_STOP = p; CMD_VALID = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        check("busy_after_accept", BUSY, 1'b1);
        lat = 0;
        while (DONE !== 1'b1 && lat < 400) begin @(negedge CLK); lat++; end
        aerr = ACK_ERR;
        check("ready_with_done", CMD_READY, 1'b1);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        check(tag, {24'd0, got}, {24'd0, exp});
    endtask

    task automatic after_done(input string tag);
        @(negedge CLK);
        check({tag, "_done_1cyc"}, DONE, 1'b0);
        check({tag, "_ackerr_lo"}, ACK_ERR, 1'b0);
    endtask

    initial begin
        int   lat;
        logic aerr;
        int   hi_cnt;
        int   done_cnt;

        // Reset state
        #12;
        check("rst_ready", CMD_READY, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_scl", SCL_O, 1'b1);
        check("rst_sda", SDA_O, 1'b1);
        check("rst_oe", SDA_OE, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_ackerr", ACK_ERR, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // 0x44 with START and STOP: 23 phases
        send(8'h44, 1'b1, 1'b1, lat, aerr);
        check("t1_lat", lat, 92);
        check("t1_ackerr", aerr, 1'b0);
        after_done("t1");
        expect_rx("t1_rx", 8'h44);
        check("t1_idle_scl", SCL_O, 1'b1);
        check("t1_idle_oe", SDA_OE, 1'b0);
        check("t1_idle_sda", SDA_O, 1'b1);

        // 0xC0 open-ended, then 0x7F continuing without START and closing
        send(8'hC0, 1'b1, 1'b0, lat, aerr);
        check("t2a_lat", lat, 80);
        after_done("t2a");
        hi_cnt = 0;
        repeat (6) begin @(negedge CLK); if (SCL_O !== 1'b0) hi_cnt++; end
        check("t2_gap_scl_low", hi_cnt, 0);
        check("t2_gap_oe", SDA_OE, 1'b1);
        check("t2_gap_sda", SDA_O, 1'b0);
        send(8'h7F, 1'b0, 1'b1, lat, aerr);
        check("t2b_lat", lat, 84);
        after_done("t2b");
        expect_rx("t2a_rx", 8'hC0);
        expect_rx("t2b_rx", 8'h7F);
        check("t2_idle_scl", SCL_O, 1'b1);

        // Repeated START on an open bus
        send(8'h11, 1'b1, 1'b0, lat, aerr);
        check("t3a_lat", lat, 80);
        after_done("t3a");
        hi_cnt = rs_cnt;
        send(8'h22, 1'b1, 1'b0, lat, aerr);
        check("t3b_lat", lat, 88);
        after_done("t3b");
        check("t3_restart_seen", rs_cnt, hi_cnt + 1);
        send(8'h33, 1'b0, 1'b1, lat, aerr);
        check("t3c_lat", lat, 84);
        after_done("t3c");
        expect_rx("t3a_rx", 8'h11);
        expect_rx("t3b_rx", 8'h22);
        expect_rx("t3c_rx", 8'h33);

        // Device withholds ACK: STOP forced even though not requested
        nack_mode = 1'b1;
        send(8'h55, 1'b1, 1'b0, lat, aerr);
        check("t4_lat", lat, 92);
        check("t4_ackerr", aerr, 1'b1);
        after_done("t4");
        nack_mode = 1'b0;
        expect_rx("t4_rx", 8'h55);
        check("t4_bus_closed_scl", SCL_O, 1'b1);
        check("t4_bus_closed_oe", SDA_OE, 1'b0);
        check("t4_model_closed", m_open, 1'b0);

        // CMD_VALID held through a transfer
        CMD_DATA = 8'h01; CMD_START = 1'b1; CMD_STOP = 1'b1; CMD_VALID = 1'b1;
        @(negedge CLK);
        check("t5_busy1", BUSY, 1'b1);
        CMD_DATA = 8'hFF; CMD_START = 1'b0; CMD_STOP = 1'b0;
        lat = 0;
        while (DONE !== 1'b1 && lat < 400) begin @(negedge CLK); lat++; end
        check("t5_lat1", lat, 92);
        CMD_DATA = 8'h02; CMD_START = 1'b1; CMD_STOP = 1'b1;
        @(negedge CLK);
        check("t5_no_take_in_done", BUSY, 1'b0);
        @(negedge CLK);
        check("t5_busy2", BUSY, 1'b1);
        CMD_VALID = 1'b0;
        lat = 0;
        while (DONE !== 1'b1 && lat < 400) begin @(negedge CLK); lat++; end
        check("t5_lat2", lat, 92);
        after_done("t5");
        check("t5_rx_count", rx_q.size(), 2);
        expect_rx("t5_rx1", 8'h01);
        expect_rx("t5_rx2", 8'h02);

        // Reset during bit 3
        CMD_DATA = 8'h5A; CMD_START = 1'b1; CMD_STOP = 1'b1; CMD_VALID = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (33) @(negedge CLK);
        check("t6_in_bit_scl", SCL_O, 1'b0);
        RESET = 1'b0;
        #1;
        check("t6_rst_scl", SCL_O, 1'b1);
        check("t6_rst_oe", SDA_OE, 1'b0);
        check("t6_rst_sda", SDA_O, 1'b1);
        check("t6_rst_ready", CMD_READY, 1'b1);
        done_cnt = 0;
        repeat (3) begin @(negedge CLK); if (DONE !== 1'b0) done_cnt++; end
        RESET = 1'b1;
        repeat (100) begin @(negedge CLK); if (DONE !== 1'b0) done_cnt++; end
        check("t6_no_done", done_cnt, 0);
        check("t6_no_partial_rx", rx_q.size(), 0);
        send(8'h3C, 1'b1, 1'b1, lat, aerr);
        check("t6_lat", lat, 92);
        check("t6_ackerr", aerr, 1'b0);
        after_done("t6");
        expect_rx("t6_rx", 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tm1637_link.md
TM1637_LINK -- requirements
Module: tm1637_link

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, CLK cycles per bus phase (legal range 2..255).
REQ-002 SHALL have port CLK  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port RESET  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port CMD_VALID  in  1  byte request.
REQ-005 SHALL have port CMD_READY  out  1  block can accept a request.
REQ-006 SHALL have port CMD_DATA  in  8  byte to send, LSB first.
REQ-007 SHALL have port CMD_START  in  1  precede the byte with START.
REQ-008 SHALL have port CMD_STOP  in  1  follow the byte with STOP.
REQ-009 SHALL have port DONE  out  1  one-cycle completion pulse.
REQ-010 SHALL have port ACK_ERR  out  1  valid with DONE; 1 = no ACK from device.
REQ-011 SHALL have port BUSY  out  1  equals ~CMD_READY.
REQ-012 SHALL have port SCL_O  out  1  display CLK line (drives P73).
REQ-013 SHALL have ports SDA_O  out  1 and SDA_OE  out  1  DIO drive value and enable (P50 = SDA_OE ? SDA_O : Z).
REQ-014 SHALL have port SDA_I  in  1  DIO pin readback.

Function
REQ-015 SHALL accept a request on a rising CLK edge with CMD_VALID & CMD_READY and capture CMD_DATA/START/STOP; CMD_READY SHALL be 0 from the next cycle until DONE.
REQ-016 SHALL ignore CMD_VALID while CMD_READY=0, with no effect on the transfer in progress.
REQ-017 SHALL hold every phase for exactly CLK_DIV cycles, counted by an internal divider that restarts on acceptance.
REQ-018 SHALL run these states: IDLE, RS_A (SCL0, SDA1), RS_B (SCL1, SDA1), ST_A (SCL1, SDA0), ST_B (SCL0, SDA0), BIT_LO (SCL0, SDA=bit), BIT_HI (SCL1, SDA=bit), ACK_LO (SCL0, SDA released), ACK_HI (SCL1, released), SP_A (SCL0, SDA0), SP_B (SCL1, SDA0), SP_C (SCL1, SDA released).
REQ-019 SHALL send 8 bits, LSB first, as BIT_LO/BIT_HI pairs driven push-pull (SDA_OE=1), using a 3-bit counter that wraps from 7 to ACK_LO.
REQ-020 SHALL sample SDA_I on the last cycle of ACK_HI; a value of 1 sets ACK_ERR.
REQ-021 SHALL keep a bus_open flag: set at ST_A, cleared at SP_C.
REQ-022 With CMD_START=1 and bus_open=1, SHALL run RS_A, RS_B, then ST_A (repeated start).
REQ-023 With CMD_START=0 and bus_open=0, SHALL force a START anyway.
REQ-024 After ACK_HI, SHALL run SP_A..SP_C if CMD_STOP=1 or on NACK; otherwise SHALL go to IDLE holding SCL0, SDA0 driven.
REQ-025 In IDLE with bus_open=0, SHALL drive SCL_O=1, SDA_OE=0 and SDA_O=1.
REQ-026 SHALL pulse DONE for one cycle on the IDLE entry edge, with CMD_READY=1 in that same cycle; ACK_ERR SHALL equal 0 whenever DONE=0.
REQ-027 Acceptance-to-DONE latency SHALL be N*CLK_DIV cycles, with N = 18 + 2 (START) + 2 (restart) + 3 (STOP/NACK), each term counted only when applicable.
REQ-028 A request arriving in the same cycle as DONE SHALL NOT be accepted; acceptance is possible from the following cycle.

Reset
REQ-029 RESET=0 SHALL asynchronously force IDLE, bus_open=0, SCL_O=1, SDA_O=1, SDA_OE=0, CMD_READY=1, BUSY=0, DONE=0, ACK_ERR=0 and clear the counters.
REQ-030 Reset mid-transfer SHALL abort with no DONE; lines SHALL go to the idle levels immediately.

Structure
REQ-031 Package tm1637_pkg SHALL hold: the state enumeration; command constants C_DATA_AUTO=0x40, C_ADDR0=0xC0, C_DISP_ON=0x88 (OR brightness 0-7); 7-segment glyph constants.
REQ-032 The block SHALL be a single module with no sub-module; divider, bit counter and FSM are inline.

Verification (CLK_DIV=4, device model ACKs unless stated)
REQ-033 SHALL cover: 0x44, START=1, STOP=1 -> DIO valid at SCL rises reads bits 0,0,1,0,0,0,1,0; DONE at 92 cycles; ACK_ERR=0; lines idle afterwards.
REQ-034 SHALL cover: 0xC0 START=1 STOP=0, then 0x7F START=0 STOP=1 -> SCL stays 0 between bytes; DONE at 80 then 84 cycles after their respective accepts.
REQ-035 SHALL cover: model withholds ACK -> ACK_ERR=1 with DONE; STOP is forced; bus_open=0.
REQ-036 SHALL cover: byte with START=1 after STOP=0 -> RS_A/RS_B seen; DONE at 88 cycles.
REQ-037 SHALL cover: CMD_VALID held while BUSY -> exactly one transfer per DONE, no dropped or duplicated bytes.
REQ-038 SHALL cover: RESET asserted at bit 3 -> SCL=1 and SDA released in the same cycle; no DONE; the next request completes normally.
